// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, shift modes, branch conditions and FSM states.
package seq_alu_pkg;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      ADDI = 3'd1,
      AND  = 3'd2,
      XOR  = 3'd3,
      BHS  = 3'd4,
      SFT  = 3'd5
   } op_mne;

   typedef enum logic [1:0] {LSL, LSR, ASR, ROL} sft_mode_e;

   typedef enum logic [1:0] {BLTU, BNE, BEQ, BLTS} br_cond_e;

   typedef enum logic {IDLE, SHIFT} alu_state_e;

endpackage

// File: rtl/seq_alu_shift_step.sv
// One-bit shift/rotate of a W-bit value; the iterative shifter applies this once per SHIFT cycle.
module seq_shift_step
   import seq_alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] din,
   input  sft_mode_e    mode,
   output logic [W-1:0] dout
);

   always_comb begin
      dout = din;
      case (mode)
         LSL:     dout = {din[W-2:0], 1'b0};
         LSR:     dout = {1'b0, din[W-1:1]};
         ASR:     dout = {din[W-1], din[W-1:1]};
         default: dout = {din[W-2:0], din[W-1]};
      endcase
   end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with Start/Done handshake: single-cycle arithmetic/logic/compare and an
// iterative one-bit-per-cycle shifter. Results and status flags are registered.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter  int W   = 8,
   parameter  int Ops = 3,
   localparam int CW  = $clog2(W) + 1
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic [W-1:0]   InputA,
   input  logic [W-1:0]   InputB,
   input  logic [Ops-1:0] OP,
   input  logic [1:0]     SMode,
   input  logic [1:0]     Branches,
   output logic           Ready,
   output logic           Done,
   output logic [W-1:0]   Out,
   output logic           RelFlag,
   output logic           Zero,
   output logic           Carry
);

   alu_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  shreg_q, shreg_d, step_out;
   sft_mode_e     smode_q, smode_d;
   logic [W-1:0]  out_q, out_d;
   logic          done_q, done_d, rel_q, rel_d, zero_q, zero_d, carry_q, carry_d;

   logic          accept, upd, undef, res_carry, res_rel;
   logic [W-1:0]  res;
   logic [W:0]    sum;
   logic [CW-1:0] n_sft;

   // Shift counts at or beyond the width all behave as exactly W steps.
   function automatic logic [CW-1:0] clamp_cnt(input logic [W-1:0] b);
      logic [CW-1:0] n;
      if (b >= W'(W)) n = CW'(W);
      else            n = CW'(b);
      return n;
   endfunction

   function automatic logic br_taken(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      logic t;
      case (br_cond_e'(c))
         BLTU:    t = (a < b);
         BNE:     t = (a != b);
         BEQ:     t = (a == b);
         default: t = ($signed(a) < $signed(b));
      endcase
      return t;
   endfunction

   seq_shift_step #(.W(W)) u_step (
      .din  (shreg_q),
      .mode (smode_q),
      .dout (step_out)
   );

   assign Ready   = (state_q == IDLE);
   assign accept  = Start & Ready;
   assign sum     = {1'b0, InputA} + {1'b0, InputB};
   assign n_sft   = clamp_cnt(InputB);
   assign Done    = done_q;
   assign Out     = out_q;
   assign RelFlag = rel_q;
   assign Zero    = zero_q;
   assign Carry   = carry_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      smode_d   = smode_q;
      out_d     = out_q;
      rel_d     = rel_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      done_d    = 1'b0;
      upd       = 1'b0;
      undef     = 1'b0;
      res       = '0;
      res_carry = 1'b0;
      res_rel   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               upd = 1'b1;
               case (OP)
                  ADD, ADDI: {res_carry, res} = sum;
                  AND:       res = InputA & InputB;
                  XOR:       res = InputA ^ InputB;
                  BHS: begin
                     res     = InputA;
                     res_rel = br_taken(Branches, InputA, InputB);
                  end
                  SFT: begin
                     res = InputA;
                     if (n_sft != '0) begin
                        upd     = 1'b0;
                        shreg_d = InputA;
                        cnt_d   = n_sft;
                        smode_d = sft_mode_e'(SMode);
                        state_d = SHIFT;
                     end
                  end
                  default: undef = 1'b1;
               endcase
            end
         end
         default: begin
            shreg_d = step_out;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               upd     = 1'b1;
               res     = step_out;
               state_d = IDLE;
            end
         end
      endcase

      // Undefined opcodes report Out=0 with every flag cleared, including Zero.
      if (upd) begin
         out_d   = res;
         carry_d = res_carry;
         rel_d   = res_rel;
         zero_d  = ~undef & (res == '0);
         done_d  = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         rel_q   <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
         rel_q   <= rel_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   always_ff @(posedge Clk) begin
      shreg_q <= shreg_d;
      smode_q <= smode_d;
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for all ops plus reset, back-to-back and busy-Start sequences.
module tb_seq_alu;
   import seq_alu_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset, Start;
   logic [7:0] InputA, InputB;
   logic [2:0] OP;
   logic [1:0] SMode, Branches;
   logic       Ready, Done, RelFlag, Zero, Carry;
   logic [7:0] Out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] sm;
      logic [1:0] br;
      logic [7:0] out;
      logic       rel;
      logic       zero;
      logic       carry;
      int         lat;
   } vec_t;

   vec_t vecs[18];

   seq_alu #(.W(8), .Ops(3)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .InputA(InputA), .InputB(InputB),
      .OP(OP), .SMode(SMode), .Branches(Branches), .Ready(Ready), .Done(Done),
      .Out(Out), .RelFlag(RelFlag), .Zero(Zero), .Carry(Carry)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h req=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Issues one op, scrambles inputs after the accept edge, then waits for Done.
   task automatic run_vec(input int idx, input vec_t v);
      int k, rlo;
      string tag;
      tag = $sformatf("v%0d", idx);
      InputA = v.a; InputB = v.b; OP = v.op; SMode = v.sm; Branches = v.br; Start = 1'b1;
      tick();
      Start = 1'b0; InputA = ~v.a; InputB = 8'h00; OP = ADD; SMode = ~v.sm; Branches = ~v.br;
      k = 0; rlo = 0;
      while (!Done && k < 20) begin
         if (!Ready) rlo++;
         tick();
         k++;
      end
      chk({tag, "_lat"}, k, v.lat);
      chk({tag, "_readylo"}, rlo, v.lat);
      chk({tag, "_ready"}, int'(Ready), 1);
      chk({tag, "_out"}, int'(Out), int'(v.out));
      chk({tag, "_rel"}, int'(RelFlag), int'(v.rel));
      chk({tag, "_zero"}, int'(Zero), int'(v.zero));
      chk({tag, "_carry"}, int'(Carry), int'(v.carry));
      tick();
      chk({tag, "_donepulse"}, int'(Done), 0);
      chk({tag, "_hold"}, int'(Out), int'(v.out));
   endtask

   initial begin
      int seen;
      vecs[0]  = '{ADD,  8'hF0, 8'h20, 2'd0, 2'd0, 8'h10, 1'b0, 1'b0, 1'b1, 0};
      vecs[1]  = '{ADDI, 8'hFF, 8'h01, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
      vecs[2]  = '{ADD,  8'h01, 8'h02, 2'd0, 2'd0, 8'h03, 1'b0, 1'b0, 1'b0, 0};
      vecs[3]  = '{AND,  8'hF0, 8'h3C, 2'd0, 2'd0, 8'h30, 1'b0, 1'b0, 1'b0, 0};
      vecs[4]  = '{XOR,  8'h0F, 8'h0F, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 0};
      vecs[5]  = '{BHS,  8'hFE, 8'h01, 2'd0, 2'd3, 8'hFE, 1'b1, 1'b0, 1'b0, 0};
      vecs[6]  = '{BHS,  8'hFE, 8'h01, 2'd0, 2'd0, 8'hFE, 1'b0, 1'b0, 1'b0, 0};
      vecs[7]  = '{BHS,  8'h05, 8'h05, 2'd0, 2'd1, 8'h05, 1'b0, 1'b0, 1'b0, 0};
      vecs[8]  = '{BHS,  8'h05, 8'h05, 2'd0, 2'd2, 8'h05, 1'b1, 1'b0, 1'b0, 0};
      vecs[9]  = '{SFT,  8'h90, 8'd3,  2'd2, 2'd0, 8'hF2, 1'b0, 1'b0, 1'b0, 3};
      vecs[10] = '{SFT,  8'h81, 8'd1,  2'd3, 2'd0, 8'h03, 1'b0, 1'b0, 1'b0, 1};
      vecs[11] = '{SFT,  8'hFF, 8'd200,2'd1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8};
      vecs[12] = '{SFT,  8'h5A, 8'd0,  2'd0, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 0};
      vecs[13] = '{SFT,  8'h81, 8'd2,  2'd0, 2'd0, 8'h04, 1'b0, 1'b0, 1'b0, 2};
      vecs[14] = '{SFT,  8'h80, 8'd9,  2'd2, 2'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8};
      vecs[15] = '{SFT,  8'hA5, 8'd8,  2'd3, 2'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 8};
      vecs[16] = '{3'd7, 8'h00, 8'h00, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 0};
      vecs[17] = '{3'd6, 8'hFF, 8'hFF, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 0};

      Reset = 1'b1; Start = 1'b0; InputA = '0; InputB = '0; OP = ADD; SMode = '0; Branches = '0;
      repeat (3) tick();
      Reset = 1'b0;
      chk("rst_ready", int'(Ready), 1);
      chk("rst_done", int'(Done), 0);
      chk("rst_out", int'(Out), 0);
      chk("rst_flags", int'({RelFlag, Zero, Carry}), 0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Reset in the middle of a long shift: no Done may ever follow.
      InputA = 8'hFF; InputB = 8'd6; OP = SFT; SMode = 2'd0; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick(); tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("midrst_ready", int'(Ready), 1);
      chk("midrst_done", int'(Done), 0);
      chk("midrst_out", int'(Out), 0);
      seen = 0;
      repeat (10) begin
         tick();
         if (Done) seen++;
      end
      chk("midrst_nodone", seen, 0);

      // Start held high across two single-cycle ops.
      InputA = 8'h01; InputB = 8'h02; OP = ADD; Start = 1'b1;
      tick();
      chk("b2b_done1", int'(Done), 1);
      chk("b2b_out1", int'(Out), 8'h03);
      InputA = 8'h0F; InputB = 8'h0F; OP = XOR;
      tick();
      Start = 1'b0;
      chk("b2b_done2", int'(Done), 1);
      chk("b2b_out2", int'(Out), 8'h00);
      chk("b2b_zero2", int'(Zero), 1);
      tick();
      chk("b2b_end", int'(Done), 0);

      // Start raised while shifting is dropped, not queued.
      InputA = 8'h01; InputB = 8'd3; OP = SFT; SMode = 2'd0; Start = 1'b1;
      tick();
      InputA = 8'hFF; InputB = 8'hFF; OP = ADD;
      tick(); tick();
      chk("busy_notdone", int'(Done), 0);
      tick();
      Start = 1'b0;
      chk("busy_done", int'(Done), 1);
      chk("busy_out", int'(Out), 8'h08);
      seen = 0;
      repeat (4) begin
         tick();
         if (Done) seen++;
      end
      chk("busy_noqueue", seen, 0);
      chk("busy_hold", int'(Out), 8'h08);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
